// File: rtl/d_hazard_ctrl_pkg.sv
// Shared encodings for the decode-stage hazard / branch control slice.
package d_hazard_ctrl_pkg;

   // Branch condition selects (s_D_cmp); 6 and 7 are unused and compare false
   typedef enum logic [2:0] {
      CMP_EQ  = 3'd0,
      CMP_NE  = 3'd1,
      CMP_LEZ = 3'd2,
      CMP_GTZ = 3'd3,
      CMP_LTZ = 3'd4,
      CMP_GEZ = 3'd5
   } cmp_sel_e;

   // D-stage forward selects
   localparam logic [1:0] FW_REG = 2'd0;
   localparam logic [1:0] FW_E   = 2'd1;
   localparam logic [1:0] FW_M   = 2'd2;
   localparam logic [1:0] FW_W   = 2'd3;

   // E/M-stage forward selects (value 2 is never used for M)
   localparam logic [1:0] FWE_REG = 2'd0;
   localparam logic [1:0] FWE_M   = 2'd1;
   localparam logic [1:0] FWE_W   = 2'd2;

   // A later stage writing a non-zero register that matches the source field
   function automatic logic reg_hit(input logic [4:0] wreg, input logic [4:0] src);
      return (src != 5'd0) && (wreg == src);
   endfunction

endpackage

// File: rtl/d_hazard_ctrl_if.sv
// Pipeline-side signal bundle for d_hazard_ctrl.
interface d_hazard_ctrl_if;
   logic [1:0]  T_use_rs, T_use_rt;
   logic [1:0]  D_T_new, E_T_new, M_T_new;
   logic [4:0]  E_Wreg, M_Wreg, W_Wreg;
   logic        W_GRF_WE;
   logic [4:0]  D_rs, D_rt, E_rs, E_rt, M_rs, M_rt, W_rs, W_rt;
   logic        E_is_SW, E_is_LW, M_is_SW, M_is_LW, W_is_LW;
   logic [31:0] D_Rdata1, D_Rdata2;
   logic [2:0]  s_D_cmp;
   logic [15:0] D_imm16;
   logic [25:0] D_imm26;
   logic [31:0] D_pc, D_adder;
   logic        stall;
   logic [1:0]  s_D_rs_data, s_D_rt_data;
   logic [1:0]  s_E_rs_data, s_E_rt_data;
   logic [1:0]  s_M_rt_data;
   logic        D_equal;
   logic [31:0] D_imm16_EXT, D_imm26_EXT;
   logic [31:0] stall_cnt;

   modport master (
      output T_use_rs, T_use_rt, D_T_new, E_T_new, M_T_new,
             E_Wreg, M_Wreg, W_Wreg, W_GRF_WE,
             D_rs, D_rt, E_rs, E_rt, M_rs, M_rt, W_rs, W_rt,
             E_is_SW, E_is_LW, M_is_SW, M_is_LW, W_is_LW,
             D_Rdata1, D_Rdata2, s_D_cmp, D_imm16, D_imm26, D_pc, D_adder,
      input  stall, s_D_rs_data, s_D_rt_data, s_E_rs_data, s_E_rt_data,
             s_M_rt_data, D_equal, D_imm16_EXT, D_imm26_EXT, stall_cnt
   );

   modport slave (
      input  T_use_rs, T_use_rt, D_T_new, E_T_new, M_T_new,
             E_Wreg, M_Wreg, W_Wreg, W_GRF_WE,
             D_rs, D_rt, E_rs, E_rt, M_rs, M_rt, W_rs, W_rt,
             E_is_SW, E_is_LW, M_is_SW, M_is_LW, W_is_LW,
             D_Rdata1, D_Rdata2, s_D_cmp, D_imm16, D_imm26, D_pc, D_adder,
      output stall, s_D_rs_data, s_D_rt_data, s_E_rs_data, s_E_rt_data,
             s_M_rt_data, D_equal, D_imm16_EXT, D_imm26_EXT, stall_cnt
   );
endinterface

// File: rtl/d_hazard_ctrl_branch_cmp.sv
// Decode-stage branch comparator and branch/jump target extender.
module d_branch_cmp
   import d_hazard_ctrl_pkg::*;
(
   input  logic [31:0] rdata1,
   input  logic [31:0] rdata2,
   input  logic [2:0]  s_cmp,
   input  logic [15:0] imm16,
   input  logic [25:0] imm26,
   input  logic [31:0] pc,
   input  logic [31:0] adder,
   output logic        equal,
   output logic [31:0] imm16_ext,
   output logic [31:0] imm26_ext
);

   // Signed branch condition on the forwarded operands
   always_comb begin
      equal = 1'b0;
      case (cmp_sel_e'(s_cmp))
         CMP_EQ:  equal = (rdata1 == rdata2);
         CMP_NE:  equal = (rdata1 != rdata2);
         CMP_LEZ: equal = ($signed(rdata1) <= 32'sd0);
         CMP_GTZ: equal = ($signed(rdata1) >  32'sd0);
         CMP_LTZ: equal = ($signed(rdata1) <  32'sd0);
         CMP_GEZ: equal = ($signed(rdata1) >= 32'sd0);
         default: equal = 1'b0;
      endcase
   end

   // PC-relative branch target and pseudo-direct jump target
   always_comb begin
      imm16_ext = adder + {{14{imm16[15]}}, imm16, 2'b00};
      imm26_ext = {pc[31:28], imm26, 2'b00};
   end

endmodule

// File: rtl/d_hazard_ctrl.sv
// Decode-stage stall/forwarding control with branch compare and stall counter.
module d_hazard_ctrl
   import d_hazard_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   d_hazard_ctrl_if.slave bus
);

   logic        stall_w;
   logic [31:0] stall_cnt_d, stall_cnt_q;

   // Stall when an in-flight producer cannot deliver before the operand is used
   always_comb begin
      stall_w = 1'b0;
      if (reg_hit(bus.E_Wreg, bus.D_rs) && (bus.T_use_rs < bus.E_T_new)) stall_w = 1'b1;
      if (reg_hit(bus.M_Wreg, bus.D_rs) && (bus.T_use_rs < bus.M_T_new)) stall_w = 1'b1;
      if (reg_hit(bus.E_Wreg, bus.D_rt) && (bus.T_use_rt < bus.E_T_new)) stall_w = 1'b1;
      if (reg_hit(bus.M_Wreg, bus.D_rt) && (bus.T_use_rt < bus.M_T_new)) stall_w = 1'b1;
   end

   // D-stage forwarding, nearest ready producer wins (E > M > W)
   always_comb begin
      s_d_rs: begin
         bus.s_D_rs_data = FW_REG;
         if      (reg_hit(bus.E_Wreg, bus.D_rs) && bus.E_T_new == 2'd0) bus.s_D_rs_data = FW_E;
         else if (reg_hit(bus.M_Wreg, bus.D_rs) && bus.M_T_new == 2'd0) bus.s_D_rs_data = FW_M;
         else if (reg_hit(bus.W_Wreg, bus.D_rs) && bus.W_GRF_WE)        bus.s_D_rs_data = FW_W;
      end
      s_d_rt: begin
         bus.s_D_rt_data = FW_REG;
         if      (reg_hit(bus.E_Wreg, bus.D_rt) && bus.E_T_new == 2'd0) bus.s_D_rt_data = FW_E;
         else if (reg_hit(bus.M_Wreg, bus.D_rt) && bus.M_T_new == 2'd0) bus.s_D_rt_data = FW_M;
         else if (reg_hit(bus.W_Wreg, bus.D_rt) && bus.W_GRF_WE)        bus.s_D_rt_data = FW_W;
      end
   end

   // E- and M-stage forwarding from later stages
   always_comb begin
      bus.s_E_rs_data = FWE_REG;
      bus.s_E_rt_data = FWE_REG;
      bus.s_M_rt_data = FWE_REG;
      if      (reg_hit(bus.M_Wreg, bus.E_rs) && bus.M_T_new == 2'd0) bus.s_E_rs_data = FWE_M;
      else if (reg_hit(bus.W_Wreg, bus.E_rs) && bus.W_GRF_WE)        bus.s_E_rs_data = FWE_W;
      if      (reg_hit(bus.M_Wreg, bus.E_rt) && bus.M_T_new == 2'd0) bus.s_E_rt_data = FWE_M;
      else if (reg_hit(bus.W_Wreg, bus.E_rt) && bus.W_GRF_WE)        bus.s_E_rt_data = FWE_W;
      if (reg_hit(bus.W_Wreg, bus.M_rt) && bus.W_GRF_WE)             bus.s_M_rt_data = FWE_M;
   end

   // Saturating stall counter next value
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_w && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   // Counter register, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) stall_cnt_q <= '0;
      else      stall_cnt_q <= stall_cnt_d;
   end

   assign bus.stall     = stall_w;
   assign bus.stall_cnt = stall_cnt_q;

   d_branch_cmp u_branch_cmp (
      .rdata1    (bus.D_Rdata1),
      .rdata2    (bus.D_Rdata2),
      .s_cmp     (bus.s_D_cmp),
      .imm16     (bus.D_imm16),
      .imm26     (bus.D_imm26),
      .pc        (bus.D_pc),
      .adder     (bus.D_adder),
      .equal     (bus.D_equal),
      .imm16_ext (bus.D_imm16_EXT),
      .imm26_ext (bus.D_imm26_EXT)
   );

endmodule

// File: tb/tb_d_hazard_ctrl.sv
// Randomized bench for d_hazard_ctrl against a table-driven reference model.
module tb_d_hazard_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   d_hazard_ctrl_if bus();

   d_hazard_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   bit          chk_en  = 1'b0;
   logic [31:0] m_cnt   = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: scan producers nearest-first, each with its "value available" condition
   function automatic logic [1:0] m_dfwd(input logic [4:0] src);
      logic [4:0] wr [3];
      bit         rdy[3];
      wr[0] = bus.E_Wreg; rdy[0] = (bus.E_T_new == 0);
      wr[1] = bus.M_Wreg; rdy[1] = (bus.M_T_new == 0);
      wr[2] = bus.W_Wreg; rdy[2] = bus.W_GRF_WE;
      if (src == 0) return 2'd0;
      for (int i = 0; i < 3; i++)
         if (wr[i] == src && rdy[i]) return 2'(i + 1);
      return 2'd0;
   endfunction

   function automatic logic [1:0] m_efwd(input logic [4:0] src);
      if (src == 0) return 2'd0;
      if (bus.M_Wreg == src && bus.M_T_new == 0) return 2'd1;
      if (bus.W_Wreg == src && bus.W_GRF_WE) return 2'd2;
      return 2'd0;
   endfunction

   function automatic bit m_stall();
      int tuse[2];
      logic [4:0] src[2];
      bit s = 0;
      tuse[0] = bus.T_use_rs; src[0] = bus.D_rs;
      tuse[1] = bus.T_use_rt; src[1] = bus.D_rt;
      for (int k = 0; k < 2; k++) begin
         if (src[k] != 0 && bus.E_Wreg == src[k] && tuse[k] < int'(bus.E_T_new)) s = 1;
         if (src[k] != 0 && bus.M_Wreg == src[k] && tuse[k] < int'(bus.M_T_new)) s = 1;
      end
      return s;
   endfunction

   function automatic bit m_equal();
      int a, b;
      a = int'(bus.D_Rdata1);
      b = int'(bus.D_Rdata2);
      case (bus.s_D_cmp)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd2: return a <= 0;
         3'd3: return a > 0;
         3'd4: return a < 0;
         3'd5: return a >= 0;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] m_imm16();
      int off;
      off = int'(shortint'(bus.D_imm16)) * 4;
      return bus.D_adder + 32'(off);
   endfunction

   function automatic logic [31:0] m_imm26();
      return (bus.D_pc & 32'hF000_0000) | (32'(bus.D_imm26) * 32'd4);
   endfunction

   // Counter model
   always @(posedge clk) begin
      if (!rst) m_cnt = 32'd0;
      else if (m_stall() && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
   end

   // Per-cycle compare of all outputs
   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall",       32'(bus.stall),       32'(m_stall()));
         chk("s_D_rs_data", 32'(bus.s_D_rs_data), 32'(m_dfwd(bus.D_rs)));
         chk("s_D_rt_data", 32'(bus.s_D_rt_data), 32'(m_dfwd(bus.D_rt)));
         chk("s_E_rs_data", 32'(bus.s_E_rs_data), 32'(m_efwd(bus.E_rs)));
         chk("s_E_rt_data", 32'(bus.s_E_rt_data), 32'(m_efwd(bus.E_rt)));
         chk("s_M_rt_data", 32'(bus.s_M_rt_data),
             32'((bus.M_rt != 0 && bus.M_rt == bus.W_Wreg && bus.W_GRF_WE) ? 1 : 0));
         chk("D_equal",     32'(bus.D_equal),     32'(m_equal()));
         chk("D_imm16_EXT", bus.D_imm16_EXT,      m_imm16());
         chk("D_imm26_EXT", bus.D_imm26_EXT,      m_imm26());
         chk("stall_cnt",   bus.stall_cnt,        m_cnt);
      end
   end

   task automatic clear_inputs();
      {bus.T_use_rs, bus.T_use_rt} = '1;
      {bus.D_T_new, bus.E_T_new, bus.M_T_new} = '0;
      {bus.E_Wreg, bus.M_Wreg, bus.W_Wreg, bus.W_GRF_WE} = '0;
      {bus.D_rs, bus.D_rt, bus.E_rs, bus.E_rt, bus.M_rs, bus.M_rt, bus.W_rs, bus.W_rt} = '0;
      {bus.E_is_SW, bus.E_is_LW, bus.M_is_SW, bus.M_is_LW, bus.W_is_LW} = '0;
      {bus.D_Rdata1, bus.D_Rdata2, bus.s_D_cmp} = '0;
      {bus.D_imm16, bus.D_imm26, bus.D_pc, bus.D_adder} = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_inputs();
      bus.T_use_rs = 2'($urandom_range(0, 3));
      bus.T_use_rt = 2'($urandom_range(0, 3));
      bus.D_T_new  = 2'($urandom_range(0, 3));
      bus.E_T_new  = 2'($urandom_range(0, 3));
      bus.M_T_new  = 2'($urandom_range(0, 2));
      bus.E_Wreg = 5'($urandom_range(0, 4));  bus.M_Wreg = 5'($urandom_range(0, 4));
      bus.W_Wreg = 5'($urandom_range(0, 4));  bus.W_GRF_WE = 1'($urandom);
      bus.D_rs = 5'($urandom_range(0, 4));    bus.D_rt = 5'($urandom_range(0, 4));
      bus.E_rs = 5'($urandom_range(0, 4));    bus.E_rt = 5'($urandom_range(0, 4));
      bus.M_rs = 5'($urandom_range(0, 4));    bus.M_rt = 5'($urandom_range(0, 4));
      bus.W_rs = 5'($urandom_range(0, 4));    bus.W_rt = 5'($urandom_range(0, 4));
      {bus.E_is_SW, bus.E_is_LW, bus.M_is_SW, bus.M_is_LW, bus.W_is_LW} = 5'($urandom);
      bus.D_Rdata1 = $urandom;
      case ($urandom_range(0, 3))
         0: bus.D_Rdata2 = bus.D_Rdata1;
         1: begin bus.D_Rdata1 = 32'd0; bus.D_Rdata2 = $urandom; end
         2: begin bus.D_Rdata1 = 32'h8000_0000 | 32'($urandom_range(0, 3)); bus.D_Rdata2 = $urandom; end
         default: bus.D_Rdata2 = $urandom;
      endcase
      bus.s_D_cmp = 3'($urandom_range(0, 7));
      bus.D_imm16 = 16'($urandom);
      bus.D_imm26 = 26'($urandom);
      bus.D_pc    = $urandom & 32'hFFFF_FFFC;
      bus.D_adder = bus.D_pc + 32'd4;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b0;
      // Reset held while a stall is requested: counter must stay clear
      bus.D_rs = 5'd5; bus.E_Wreg = 5'd5; bus.E_T_new = 2'd2; bus.T_use_rs = 2'd0;
      repeat (3) step();
      chk_en = 1'b1;
      chk("lit_reset_cnt", bus.stall_cnt, 32'd0);
      chk("lit_stall", 32'(bus.stall), 32'd1);
      rst = 1'b1;
      step();
      chk("lit_cnt_one", bus.stall_cnt, 32'd1);

      // Ready E producer forwards instead of stalling
      bus.E_T_new = 2'd0;
      step();
      chk("lit_no_stall", 32'(bus.stall), 32'd0);
      chk("lit_fw_e", 32'(bus.s_D_rs_data), 32'd1);
      bus.E_Wreg = 5'd0; bus.M_Wreg = 5'd5; bus.M_T_new = 2'd0;
      #1 chk("lit_fw_m", 32'(bus.s_D_rs_data), 32'd2);
      chk("lit_rt_zero", 32'(bus.s_D_rt_data), 32'd0);

      // E/M forwarding with M and W both matching
      bus.E_rs = 5'd8; bus.M_Wreg = 5'd8; bus.W_Wreg = 5'd8; bus.W_GRF_WE = 1'b1;
      bus.M_rt = 5'd8;
      #1 chk("lit_e_m_wins", 32'(bus.s_E_rs_data), 32'd1);
      chk("lit_m_fw", 32'(bus.s_M_rt_data), 32'd1);

      // Comparator and targets
      bus.s_D_cmp = 3'd0; bus.D_Rdata1 = 32'h12; bus.D_Rdata2 = 32'h12;
      #1 chk("lit_eq", 32'(bus.D_equal), 32'd1);
      bus.s_D_cmp = 3'd4; bus.D_Rdata1 = 32'h8000_0000;
      #1 chk("lit_ltz", 32'(bus.D_equal), 32'd1);
      bus.s_D_cmp = 3'd7;
      #1 chk("lit_cmp7", 32'(bus.D_equal), 32'd0);
      bus.D_adder = 32'h3004; bus.D_imm16 = 16'hFFFF;
      bus.D_pc = 32'h3000_0000; bus.D_imm26 = 26'h0000C04;
      #1 chk("lit_imm16", bus.D_imm16_EXT, 32'h3000);
      chk("lit_imm26", bus.D_imm26_EXT, 32'h3000_3010);

      // Randomized run with occasional reset pulses
      for (int i = 0; i < 400; i++) begin
         step();
         rand_inputs();
         rst = ($urandom_range(0, 19) != 0);
      end
      step();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/d_hazard_ctrl.md
# d_hazard_ctrl

Decode-stage control block for the five-stage MIPS pipeline. It merges three duties:
- the stall/forwarding decision unit (T_use/T_new scheme);
- the decode-stage branch comparator;
- the branch/jump target extender.

It sits between the D-stage register-file read and the F-stage NPC mux. It drives the forwarding-mux selects for D, E and M, and the pipeline stall. It also keeps a registered stall counter for performance checks.

## Interface
Parameters: none.
- clk  in  1  system clock
- rst  in  1  one clock; reset is synchronous and active-low
- T_use_rs, T_use_rt  in  2  cycles until D instruction needs rs/rt (3 = never)
- D_T_new, E_T_new, M_T_new  in  2  cycles until stage's result is ready (0 = ready now)
- E_Wreg, M_Wreg, W_Wreg  in  5  destination register per stage; 0 = no write
- W_GRF_WE  in  1  W stage writes GRF
- D_rs, D_rt, E_rs, E_rt, M_rs, M_rt, W_rs, W_rt  in  5  source fields per stage
- E_is_SW, E_is_LW, M_is_SW, M_is_LW, W_is_LW  in  1  instruction class flags
- D_Rdata1, D_Rdata2  in  32  forwarded rs/rt values in D
- s_D_cmp  in  3  branch condition select
- D_imm16  in  16;  D_imm26  in  26;  D_pc, D_adder  in  32  (D_adder = D_pc+4)
- stall  out  1  freeze PC and F/D, bubble D/E
- s_D_rs_data, s_D_rt_data  out  2  D forward select
- s_E_rs_data, s_E_rt_data  out  2  E forward select
- s_M_rt_data  out  2  M store-data forward select
- D_equal  out  1  branch condition true
- D_imm16_EXT, D_imm26_EXT  out  32  branch / jump targets
- stall_cnt  out  32  registered count of stalled cycles

## Operation
Stall:
- A stage X hits on rs when X_Wreg == D_rs and D_rs != 0. The same rule applies to rt.
- stall = 1 iff any E or M hit exists with T_use < X_T_new for that operand.
- W never causes a stall.

D forwarding, per operand:
- 1 if an E hit exists with E_T_new == 0.
- Otherwise 2 if an M hit exists with M_T_new == 0.
- Otherwise 3 if a W hit exists with W_GRF_WE == 1.
- Otherwise 0 (GRF).
- The priority order is E > M > W.

E forwarding, compared against E_rs/E_rt:
- 1 on an M hit with M_T_new == 0.
- Otherwise 2 on a W hit with W_GRF_WE.
- Otherwise 0.

M forwarding (s_M_rt_data):
- 1 when M_rt == W_Wreg, M_rt != 0 and W_GRF_WE.
- Otherwise 0.
- Value 2 is reserved and never driven.

Unused inputs: D_T_new, the is_* flags and M_rs, W_rs, W_rt are accepted and do not affect outputs.

D_equal by s_D_cmp (signed compares):
- 0: a == b
- 1: a != b
- 2: a <= 0
- 3: a > 0
- 4: a < 0
- 5: a >= 0
- 6 and 7: 0

Targets:
- D_imm16_EXT = D_adder + (sign_extend(D_imm16) << 2), modulo 2^32.
- D_imm26_EXT = {D_pc[31:28], D_imm26, 2'b00}.

Counter:
- stall_cnt increments by 1 on each clk edge where stall = 1.
- It saturates at 0xFFFFFFFF.

## Timing
- All outputs except stall_cnt are purely combinational, with zero latency.
- stall_cnt updates on the rising edge of clk.
- rst low at an edge sets stall_cnt to 0. Reset dominates a simultaneous stall.
- During reset, combinational outputs still follow their inputs.
- Reset asserted mid-operation clears only the counter.

## Structure
- A shared package holds:
  - the s_D_cmp encodings (CMP_EQ .. CMP_GEZ);
  - the forward-select encodings (FW_REG = 0, FW_E = 1, FW_M = 2, FW_W = 3 for D; 0/1/2 for E).
- One natural sub-module: d_branch_cmp, containing the comparator and the target extender.

## Test plan
- D_rs = 5, E_Wreg = 5, E_T_new = 2, T_use_rs = 0 -> stall = 1. At the next edge, stall_cnt increments by 1.
- D_rs = 5, E_Wreg = 5, E_T_new = 0, T_use_rs = 0 -> stall = 0, s_D_rs_data = 1. With E_Wreg = 0 and an M hit with M_T_new = 0 instead -> 2.
- D_rt = 0 with E_Wreg = 0 -> no stall, s_D_rt_data = 0.
- E_rs = 8 with M_Wreg = 8 (M_T_new = 0) and W_Wreg = 8 (W_GRF_WE = 1) -> s_E_rs_data = 1 (M wins). M_rt = 8, W_Wreg = 8, W_GRF_WE = 1 -> s_M_rt_data = 1.
- Comparator cases:
  - s_D_cmp = 0, a = b = 0x12 -> D_equal = 1.
  - s_D_cmp = 4, a = 0x80000000 -> D_equal = 1.
  - s_D_cmp = 7 -> D_equal = 0.
- Target cases:
  - D_adder = 0x3004, imm16 = 0xFFFF -> D_imm16_EXT = 0x3000.
  - D_pc = 0x30000000, imm26 = 0x0000C04 -> D_imm26_EXT = 0x30003010.
- Reset: hold rst = 0 with stall = 1 -> stall_cnt stays 0.
